seg_scan_driver: RTL and testbench

//  Parametrised time-multiplexed 7-segment scan driver with internal hex/point decode.

---
 rtl/seg_scan_driver.sv | 156 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: per-slot snapshot, hex/point decode,
// PWM brightness, per-digit blink and a blanking gap at the start of each slot.
module seg_scan_driver #(
    parameter int NUM_DIGITS        = 8,
    parameter int DIV               = 50000,
    parameter int BLANK_CYCLES      = 1000,
    parameter int BLINK_HALF_FRAMES = 62
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   en,
    input  logic [NUM_DIGITS-1:0]   en_point,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic [2:0]              bright,
    output logic [NUM_DIGITS-1:0]   seg_en,
    output logic [7:0]              seg_out,
    output logic                    frame_tick
);

    localparam int CNT_W   = $clog2(DIV);
    localparam int LEN_W   = CNT_W + 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FC_W    = (BLINK_HALF_FRAMES > 1) ? $clog2(BLINK_HALF_FRAMES) : 1;
    localparam int SLOT_ON = DIV - BLANK_CYCLES;
    localparam int STEP    = SLOT_ON >> 3;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [3:0]            snap_digit_q, snap_digit_d;
    logic                  snap_point_q, snap_point_d;
    logic                  snap_en_q, snap_en_d;
    logic                  snap_blink_q, snap_blink_d;
    logic [2:0]            snap_bright_q, snap_bright_d;
    logic [NUM_DIGITS-1:0] seg_en_q, seg_en_d;
    logic [7:0]            seg_out_q, seg_out_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  slot_end;
    logic                  lit;
    logic [LEN_W-1:0]      on_len;
    logic [LEN_W-1:0]      cnt_ext;

    function automatic logic [7:0] decode(input logic [3:0] value, input logic point);
        logic [7:0] segs;
        case (value)
            4'h0: segs = 8'hC0;
            4'h1: segs = 8'hF9;
            4'h2: segs = 8'hA4;
            4'h3: segs = 8'hB0;
            4'h4: segs = 8'h99;
            4'h5: segs = 8'h92;
            4'h6: segs = 8'h82;
            4'h7: segs = 8'hF8;
            4'h8: segs = 8'h80;
            4'h9: segs = 8'h90;
            4'hA: segs = 8'h88;
            4'hB: segs = 8'h83;
            4'hC: segs = 8'hC6;
            4'hD: segs = 8'hA1;
            4'hE: segs = 8'h86;
            default: segs = 8'h8E;
        endcase
        return segs & {~point, 7'h7F};
    endfunction

    // Slot/frame sequencing and snapshot capture.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        slot_end      = (cnt_q == CNT_W'(DIV - 1));
        cnt_d         = slot_end ? '0 : cnt_q + 1'b1;
        idx_d         = idx_q;
        snap_digit_d  = snap_digit_q;
        snap_point_d  = snap_point_q;
        snap_en_d     = snap_en_q;
        snap_blink_d  = snap_blink_q;
        snap_bright_d = snap_bright_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_tick_d  = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

        if (slot_end) begin
            idx_d         = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            snap_digit_d  = digits[4*idx_d +: 4];
            snap_point_d  = en_point[idx_d];
            snap_en_d     = en[idx_d];
            snap_blink_d  = blink[idx_d];
            snap_bright_d = bright;
        end

        if (frame_tick_q) begin
            if (frame_cnt_q == FC_W'(BLINK_HALF_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Lit window: after the blank gap, for a brightness-scaled number of cycles.
    always_comb begin
        cnt_ext = {1'b0, cnt_q};
        on_len  = (snap_bright_q == 3'd7) ? LEN_W'(SLOT_ON)
                : LEN_W'(STEP) * LEN_W'({1'b0, snap_bright_q} + 4'd1);
        lit     = (cnt_ext >= LEN_W'(BLANK_CYCLES))
               && (cnt_ext < LEN_W'(BLANK_CYCLES) + on_len)
               && snap_en_q
               && !(snap_blink_q && blink_phase_q);
        seg_en_d  = '1;
        seg_out_d = 8'hFF;
        if (lit) begin
            seg_en_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_out_d = decode(snap_digit_q, snap_point_q);
        end
    end

    // NOTE: state uses non-blocking assignments; the async reset clears every flop,
    // snapshot included, so the first slot after release is dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_digit_q  <= '0;
            snap_point_q  <= 1'b0;
            snap_en_q     <= 1'b0;
            snap_blink_q  <= 1'b0;
            snap_bright_q <= '0;
            seg_en_q      <= '1;
            seg_out_q     <= 8'hFF;
            frame_tick_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_digit_q  <= snap_digit_d;
            snap_point_q  <= snap_point_d;
            snap_en_q     <= snap_en_d;
            snap_blink_q  <= snap_blink_d;
            snap_bright_q <= snap_bright_d;
            seg_en_q      <= seg_en_d;
            seg_out_q     <= seg_out_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign seg_en     = seg_en_q;
    assign seg_out    = seg_out_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed scenarios plus random input churn,
// checked every cycle against a cycle-index arithmetic model of the scan.
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 16;
    localparam int BLANK = 4;
    localparam int BHF   = 2;
    localparam int FRAME = N * DIV;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4*N-1:0] digits;
    logic [N-1:0]   en, en_point, blink;
    logic [2:0]     bright;
    logic [N-1:0]   seg_en;
    logic [7:0]     seg_out;
    logic           frame_tick;

    seg_scan_driver #(
        .NUM_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(BLANK), .BLINK_HALF_FRAMES(BHF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .en(en), .en_point(en_point),
        .blink(blink), .bright(bright), .seg_en(seg_en), .seg_out(seg_out),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;
    int churn    = 0;

    logic [3:0] m_digit;
    logic       m_point, m_en, m_blink;
    logic [2:0] m_bright;

    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, k, got, exp);
    endtask

    function automatic int on_len(input int b);
        int slot_on = DIV - BLANK;
        return (b == 7) ? slot_on : (slot_on / 8) * (b + 1);
    endfunction

    function automatic bit phase_at(input int kk);
        if (kk == 0) return 1'b0;
        return ((((kk - 1) / FRAME) / BHF) % 2) == 1;
    endfunction

    function automatic bit lit_at(input int kk);
        int pos = kk % DIV;
        return (pos >= BLANK) && (pos < BLANK + on_len(int'(m_bright)))
            && m_en && !(m_blink && phase_at(kk));
    endfunction

    task automatic model_reset();
        k = 0; m_digit = '0; m_point = 1'b0; m_en = 1'b0; m_blink = 1'b0; m_bright = '0;
    endtask

    task automatic churn_inputs();
        int i = $urandom_range(0, N - 1);
        case ($urandom_range(0, 7))
            0: digits[4*i +: 4] = 4'($urandom);
            1: en[i]            = ~en[i];
            2: en_point[i]      = ~en_point[i];
            3: blink[i]         = ~blink[i];
            4: bright           = 3'($urandom);
            default: ;
        endcase
    endtask

    // One clock: predict outputs from the pre-edge state, advance, capture, compare.
    task automatic step();
        bit         exp_lit  = lit_at(k);
        int         exp_idx  = (k / DIV) % N;
        bit         exp_tick = ((k + 1) % FRAME) == 0;
        logic [N-1:0] exp_en = '1;
        logic [7:0] exp_seg  = 8'hFF;
        int         idx;
        if (exp_lit) begin
            exp_en[exp_idx] = 1'b0;
            exp_seg = seg_tbl[m_digit];
            if (m_point) exp_seg[7] = 1'b0;
        end
        @(posedge clk);
        k++;
        if (k % DIV == 0) begin
            idx      = (k / DIV) % N;
            m_digit  = digits[4*idx +: 4];
            m_point  = en_point[idx];
            m_en     = en[idx];
            m_blink  = blink[idx];
            m_bright = bright;
        end
        #1;
        check("seg_en", 32'(seg_en), 32'(exp_en));
        check("seg_out", 32'(seg_out), 32'(exp_seg));
        check("frame_tick", 32'(frame_tick), 32'(exp_tick));
        check("one_hot_low", 32'($countones(~seg_en) <= 1), 32'd1);
        if (churn == 1 && $urandom_range(0, 3) == 0) digits = 16'($urandom);
        if (churn == 2 && $urandom_range(0, 1) == 0) churn_inputs();
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    task automatic run_to(input int pos_in_frame);
        int budget = FRAME + 1;
        while ((k % FRAME) != pos_in_frame && budget > 0) begin
            step();
            budget--;
        end
        check("run_to_reached", 32'(k % FRAME), 32'(pos_in_frame));
    endtask

    initial begin
        rst_n = 1'b0;
        digits = 16'h3210; en = '1; en_point = '0; blink = '0; bright = 3'd7;
        #12;
        check("reset_seg_en", 32'(seg_en), 32'hF);
        check("reset_seg_out", 32'(seg_out), 32'hFF);
        check("reset_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        run(2 * FRAME);                       // full brightness, digits 0..3
        bright = 3'd0; run(FRAME + DIV);      // 1 lit cycle per slot
        bright = 3'd3; run(FRAME + DIV);      // 4 lit cycles per slot
        bright = 3'd7; en = 4'b1011; run(FRAME + DIV);
        en = '1; blink = 4'b0001; run(6 * FRAME);
        blink = '0;

        digits = 16'h7310; en_point = 4'b0010; run(FRAME);
        run_to(DIV + 8);
        check("dp_digit1", 32'(seg_out), 32'h79);
        digits[7:4] = 4'h7;
        run(4);
        check("dp_digit1_held", 32'(seg_out), 32'h79);
        run(FRAME);

        churn = 1; run(3 * FRAME);
        churn = 2; run(24 * FRAME);
        churn = 0;

        digits = 16'h3210; en = '1; en_point = '0; blink = '0; bright = 3'd7;
        run(FRAME);
        run_to(2 * DIV + 8);
        check("pre_reset_lit", 32'(seg_en), 32'hB);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_seg_en", 32'(seg_en), 32'hF);
        check("async_rst_seg_out", 32'(seg_out), 32'hFF);
        check("async_rst_tick", 32'(frame_tick), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(3 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
